// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key scheduler: expands forward to round 10, then streams keys 10..0.
// Define AES_KSCHED_SHARED_SBOX_EN to time-share one S-box over SubWord (4 cycles per step).
module aes_inv_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         start,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  if (NR != 10) begin : g_nr_chk
    $error("aes_inv_key_sched: only NR=10 is supported");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ ({8{x[7]}} & 8'h1b);
    end
    return p;
  endfunction

  // a^-1 = (a^17)^14 * a^16; a^17 is the norm into the GF(16) subfield.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a4, a8, a16, n, n2, n4, n8, ni, v;
    a2  = gmul(a, a);
    a4  = gmul(a2, a2);
    a8  = gmul(a4, a4);
    a16 = gmul(a8, a8);
    n   = gmul(a16, a);
    n2  = gmul(n, n);
    n4  = gmul(n2, n2);
    n8  = gmul(n4, n4);
    ni  = gmul(gmul(n8, n4), n2);
    v   = gmul(ni, a16);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    unique case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  typedef enum logic [1:0] {IDLE, FWD, REV} state_e;

  state_e       st_q, st_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sw_src, rw, sw, rc;
  logic [31:0]  f0, f1, f2;
  logic [127:0] fwd_key, rev_key;
  logic         xfer, step_last, rev_upd;

  assign {w0, w1, w2, w3} = key_q;
  assign sw_src = (st_q == REV) ? (w3 ^ w2) : w3;
  assign rw     = {sw_src[23:0], sw_src[31:24]};
  assign rc     = {rcon(idx_q), 24'h000000};
  assign xfer   = rk_valid & rk_ready;

  // New w0 is the same expression both ways; only the SubWord source differs.
  assign f0      = w0 ^ sw ^ rc;
  assign f1      = w1 ^ f0;
  assign f2      = w2 ^ f1;
  assign fwd_key = {f0, f1, f2, w3 ^ f2};
  assign rev_key = {f0, w1 ^ w0, w2 ^ w1, w3 ^ w2};

`ifdef AES_KSCHED_SHARED_SBOX_EN
  logic [1:0]  ph_q, ph_d;
  logic        calc_q, calc_d;
  logic [23:0] sw_q, sw_d;
  logic [7:0]  sb_in, sb;

  always_comb begin
    unique case (ph_q)
      2'd0:    sb_in = rw[31:24];
      2'd1:    sb_in = rw[23:16];
      2'd2:    sb_in = rw[15:8];
      default: sb_in = rw[7:0];
    endcase
  end

  assign sb        = sbox(sb_in);
  assign sw        = {sw_q, sb};
  assign step_last = (ph_q == 2'd3);
  assign rev_upd   = calc_q & step_last;
  assign rk_valid  = (st_q == REV) & ~calc_q;

  always_comb begin
    ph_d   = ph_q;
    calc_d = calc_q;
    sw_d   = sw_q;
    if ((st_q == FWD) || calc_q || (xfer && idx_q != 4'd0)) begin
      ph_d   = ph_q + 2'd1;
      sw_d   = {sw_q[15:0], sb};
      calc_d = (st_q == REV) && !step_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q   <= '0;
      calc_q <= 1'b0;
      sw_q   <= '0;
    end else begin
      ph_q   <= ph_d;
      calc_q <= calc_d;
      sw_q   <= sw_d;
    end
  end
`else
  assign sw        = {sbox(rw[31:24]), sbox(rw[23:16]),
                      sbox(rw[15:8]), sbox(rw[7:0])};
  assign step_last = 1'b1;
  assign rev_upd   = xfer & (idx_q != 4'd0);
  assign rk_valid  = (st_q == REV);
`endif

  always_comb begin
    st_d   = st_q;
    key_d  = key_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (start) begin
          st_d  = FWD;
          key_d = key_in;
          idx_d = 4'd1;
        end
      end
      FWD: begin
        if (step_last) begin
          key_d = fwd_key;
          if (idx_q == 4'd10) st_d = REV;
          else                idx_d = idx_q + 4'd1;
        end
      end
      REV: begin
        if (xfer && idx_q == 4'd0) begin
          st_d   = IDLE;
          done_d = 1'b1;
        end else if (rev_upd) begin
          key_d = rev_key;
          idx_d = idx_q - 4'd1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      key_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      key_q  <= key_d;
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  assign rk_out = key_q;
  assign rk_idx = idx_q;
  assign busy   = (st_q != IDLE);
  assign done   = done_q;

endmodule
